// File: rtl/instruction_fetch.sv
// instruction_fetch
//
// Front end of the pipeline. Owns the program counter and fetches one 32-bit
// instruction at a time from instruction memory over a single-outstanding
// request/response interface, then presents it to the decode stage. Honours
// stalls from hazard logic and redirects (taken branch / jump) from execute.
// A response made stale by a redirect is dropped; a NOP bubble is driven
// whenever no valid instruction is held.
//
// Ports:
//   i_clk          clock, all state changes on the rising edge
//   i_rst          synchronous, active-high reset
//   o_imem_req     one-cycle fetch request pulse
//   o_imem_addr    fetch address, valid while o_imem_req is high
//   i_imem_valid   one-cycle response strobe
//   i_imem_rdata   instruction word, valid with i_imem_valid
//   i_stall        hold the presented instruction
//   i_redirect     switch the fetch stream to i_redirect_pc
//   i_redirect_pc  redirect target, bits [1:0] ignored
//   o_valid        o_pc / o_instruction carry a real instruction
//   o_pc           PC of the presented instruction
//   o_instruction  presented instruction word, or NOP_INSTR when not valid

module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction
);

  typedef enum logic [1:0] {
    StReq,   // request is on the bus this cycle
    StWait,  // waiting for the single outstanding response
    StOut    // instruction held on the outputs
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        discard_q;  // the outstanding response belongs to an abandoned stream
  logic [31:0] instr_q;

  logic [31:0] redirect_target;
  logic        unused_redirect_bits;

  // Targets are always word aligned; the low bits are simply dropped.
  assign redirect_target      = {i_redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^i_redirect_pc[1:0];

  assign o_imem_req    = (state_q == StReq);
  assign o_imem_addr   = pc_q;
  assign o_instruction = o_valid ? instr_q : NOP_INSTR;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StReq;
      pc_q      <= RESET_PC;
      o_pc      <= RESET_PC;
      o_valid   <= 1'b0;
      discard_q <= 1'b0;
      instr_q   <= NOP_INSTR;
    end else begin
      unique case (state_q)
        StReq: begin
          // The request for the old pc still goes out this cycle, so its
          // response must be thrown away when a redirect lands here.
          state_q <= StWait;
          if (i_redirect) begin
            discard_q <= 1'b1;
            pc_q      <= redirect_target;
          end
        end

        StWait: begin
          if (i_imem_valid) begin
            if (discard_q || i_redirect) begin
              discard_q <= 1'b0;
              if (i_redirect) begin
                pc_q <= redirect_target;
              end
              state_q <= StReq;
            end else begin
              instr_q <= i_imem_rdata;
              o_pc    <= pc_q;
              o_valid <= 1'b1;
              state_q <= StOut;
            end
          end else if (i_redirect) begin
            // Repeated redirects only retarget the pc; at most one response
            // is ever outstanding, so a single discard flag is enough.
            discard_q <= 1'b1;
            pc_q      <= redirect_target;
          end
        end

        StOut: begin
          if (i_redirect) begin
            o_valid <= 1'b0;
            pc_q    <= redirect_target;
            state_q <= StReq;
          end else if (!i_stall) begin
            o_valid <= 1'b0;
            pc_q    <= pc_q + 32'd4;
            state_q <= StReq;
          end
        end

        default: begin
          state_q <= StReq;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. A behavioural instruction memory
// answers each request after mem_lat cycles; all stimulus and checks happen
// on the falling edge, one scenario per task, with cycle numbers noted.

module tb_instruction_fetch;

  logic        i_clk         = 1'b0;
  logic        i_rst         = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_valid  = 1'b0;
  logic [31:0] i_imem_rdata  = 32'h0;
  logic        i_stall       = 1'b0;
  logic        i_redirect    = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;

  int n_cmp  = 0;
  int n_fail = 0;

  int          mem_lat     = 1;
  bit          mem_pending = 1'b0;
  int          mem_cnt     = 0;
  logic [31:0] mem_addr    = 32'h0;

  instruction_fetch dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_valid  (i_imem_valid),
    .i_imem_rdata  (i_imem_rdata),
    .i_stall       (i_stall),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_instruction (o_instruction)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory shares the reset and forgets any outstanding request.
  always @(posedge i_clk) begin
    if (i_rst) mem_pending = 1'b0;
  end

  always @(negedge i_clk) begin
    i_imem_valid = 1'b0;
    if (mem_pending) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        i_imem_valid = 1'b1;
        i_imem_rdata = mem_word(mem_addr);
        mem_pending  = 1'b0;
      end
    end
    if (o_imem_req === 1'b1) begin
      mem_pending = 1'b1;
      mem_cnt     = mem_lat;
      mem_addr    = o_imem_addr;
    end
  end

  task automatic tick;
    @(negedge i_clk);
  endtask

  task automatic test_reset;
    i_rst = 1'b1; mem_lat = 1;
    tick; tick;
    i_rst = 1'b0;
    // cycle 0
    n_cmp++; if (o_imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req: got %b want 1", o_imem_req); end
    n_cmp++; if (o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 00000000", o_imem_addr); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    n_cmp++; if (o_instruction !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_instr: got %h want 00000013", o_instruction); end
    n_cmp++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 00000000", o_pc); end
    tick; // cycle 1
    n_cmp++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL l1_wait_req: got %b want 0", o_imem_req); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL l1_wait_valid: got %b want 0", o_valid); end
    tick; // cycle 2
    n_cmp++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL l1_out_valid: got %b want 1", o_valid); end
    n_cmp++; if (o_pc !== 32'h0) begin n_fail++; $display("FAIL l1_out_pc: got %h want 00000000", o_pc); end
    n_cmp++; if (o_instruction !== 32'h0010_0093) begin n_fail++; $display("FAIL l1_out_instr: got %h want 00100093", o_instruction); end
    tick; // cycle 3
    n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h4) begin n_fail++; $display("FAIL l1_next_req: got req=%b addr=%h want req=1 addr=00000004", o_imem_req, o_imem_addr); end
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL l1_next_valid: got %b want 0", o_valid); end
  endtask

  task automatic test_stall;
    tick; tick; // cycle 5
    n_cmp++; if (o_valid !== 1'b1 || o_pc !== 32'h4 || o_instruction !== 32'hC0DE_0004) begin n_fail++; $display("FAIL seq_out4: got v=%b pc=%h i=%h want v=1 pc=00000004 i=c0de0004", o_valid, o_pc, o_instruction); end
    tick; // cycle 6
    n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h8) begin n_fail++; $display("FAIL seq_req8: got req=%b addr=%h want req=1 addr=00000008", o_imem_req, o_imem_addr); end
    tick; tick; // cycle 8
    n_cmp++; if (o_valid !== 1'b1 || o_pc !== 32'h8) begin n_fail++; $display("FAIL stall_first: got v=%b pc=%h want v=1 pc=00000008", o_valid, o_pc); end
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin // cycles 9..11
      tick;
      n_cmp++; if (o_valid !== 1'b1 || o_pc !== 32'h8 || o_instruction !== 32'hC0DE_0008 || o_imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: got v=%b pc=%h i=%h req=%b want v=1 pc=00000008 i=c0de0008 req=0", k, o_valid, o_pc, o_instruction, o_imem_req); end
    end
    i_stall = 1'b0;
    tick; // cycle 12
    n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'hC || o_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got req=%b addr=%h v=%b want req=1 addr=0000000c v=0", o_imem_req, o_imem_addr, o_valid); end
  endtask

  task automatic test_redirect_priority;
    tick; tick; // cycle 14
    n_cmp++; if (o_valid !== 1'b1 || o_pc !== 32'hC) begin n_fail++; $display("FAIL pri_out: got v=%b pc=%h want v=1 pc=0000000c", o_valid, o_pc); end
    i_redirect = 1'b1; i_redirect_pc = 32'h103; i_stall = 1'b1;
    tick; // cycle 15
    i_redirect = 1'b0; i_stall = 1'b0;
    n_cmp++; if (o_valid !== 1'b0 || o_instruction !== 32'h0000_0013) begin n_fail++; $display("FAIL pri_bubble: got v=%b i=%h want v=0 i=00000013", o_valid, o_instruction); end
    n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h100) begin n_fail++; $display("FAIL pri_req: got req=%b addr=%h want req=1 addr=00000100", o_imem_req, o_imem_addr); end
    tick; tick; // cycle 17
    n_cmp++; if (o_valid !== 1'b1 || o_pc !== 32'h100 || o_instruction !== 32'hC0DE_0100) begin n_fail++; $display("FAIL pri_target: got v=%b pc=%h i=%h want v=1 pc=00000100 i=c0de0100", o_valid, o_pc, o_instruction); end
  endtask

  task automatic test_redirect_wait;
    mem_lat = 4;
    i_redirect = 1'b1; i_redirect_pc = 32'h10;
    tick; // cycle 18
    i_redirect = 1'b0;
    n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h10) begin n_fail++; $display("FAIL rw_req10: got req=%b addr=%h want req=1 addr=00000010", o_imem_req, o_imem_addr); end
    tick; tick; // cycle 20
    i_redirect = 1'b1; i_redirect_pc = 32'h200;
    tick; // cycle 21
    i_redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin // cycles 21, 22 (stale response in 22)
      n_cmp++; if (o_valid !== 1'b0 || o_imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_drop%0d: got v=%b req=%b want v=0 req=0", k, o_valid, o_imem_req); end
      if (k == 0) tick;
    end
    tick; // cycle 23
    n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h200 || o_valid !== 1'b0) begin n_fail++; $display("FAIL rw_req200: got req=%b addr=%h v=%b want req=1 addr=00000200 v=0", o_imem_req, o_imem_addr, o_valid); end
    for (int k = 0; k < 4; k++) begin // cycles 24..27
      tick;
      n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rw_latency%0d: got v=%b want 0", k, o_valid); end
    end
    tick; // cycle 28
    n_cmp++; if (o_valid !== 1'b1 || o_pc !== 32'h200 || o_instruction !== 32'hC0DE_0200) begin n_fail++; $display("FAIL rw_out200: got v=%b pc=%h i=%h want v=1 pc=00000200 i=c0de0200", o_valid, o_pc, o_instruction); end
  endtask

  task automatic test_multi_redirect;
    tick; // cycle 29
    n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h204) begin n_fail++; $display("FAIL mr_req204: got req=%b addr=%h want req=1 addr=00000204", o_imem_req, o_imem_addr); end
    i_redirect = 1'b1; i_redirect_pc = 32'h500;
    tick; // cycle 30
    i_redirect = 1'b0;
    tick; // cycle 31
    i_redirect = 1'b1; i_redirect_pc = 32'h600;
    tick; // cycle 32
    i_redirect = 1'b0;
    tick; // cycle 33, stale response
    n_cmp++; if (o_valid !== 1'b0 || o_imem_req !== 1'b0) begin n_fail++; $display("FAIL mr_drop: got v=%b req=%b want v=0 req=0", o_valid, o_imem_req); end
    tick; // cycle 34
    n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h600) begin n_fail++; $display("FAIL mr_req600: got req=%b addr=%h want req=1 addr=00000600", o_imem_req, o_imem_addr); end
    for (int k = 0; k < 4; k++) begin // cycles 35..38
      tick;
      n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mr_latency%0d: got v=%b want 0", k, o_valid); end
    end
    tick; // cycle 39
    n_cmp++; if (o_valid !== 1'b1 || o_pc !== 32'h600 || o_instruction !== 32'hC0DE_0600) begin n_fail++; $display("FAIL mr_out600: got v=%b pc=%h i=%h want v=1 pc=00000600 i=c0de0600", o_valid, o_pc, o_instruction); end
  endtask

  task automatic test_redirect_with_valid;
    mem_lat = 1;
    tick; // cycle 40
    n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h604) begin n_fail++; $display("FAIL rv_req604: got req=%b addr=%h want req=1 addr=00000604", o_imem_req, o_imem_addr); end
    tick; // cycle 41, response arrives together with the redirect
    i_redirect = 1'b1; i_redirect_pc = 32'h300;
    tick; // cycle 42
    i_redirect = 1'b0;
    n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h300 || o_valid !== 1'b0) begin n_fail++; $display("FAIL rv_req300: got req=%b addr=%h v=%b want req=1 addr=00000300 v=0", o_imem_req, o_imem_addr, o_valid); end
    tick; tick; // cycle 44
    n_cmp++; if (o_valid !== 1'b1 || o_pc !== 32'h300 || o_instruction !== 32'hC0DE_0300) begin n_fail++; $display("FAIL rv_out300: got v=%b pc=%h i=%h want v=1 pc=00000300 i=c0de0300", o_valid, o_pc, o_instruction); end
  endtask

  task automatic test_reset_mid;
    mem_lat = 4;
    i_redirect = 1'b1; i_redirect_pc = 32'h40;
    tick; // cycle 45
    i_redirect = 1'b0;
    n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h40) begin n_fail++; $display("FAIL rm_req40: got req=%b addr=%h want req=1 addr=00000040", o_imem_req, o_imem_addr); end
    tick; // cycle 46, waiting on 0x40
    i_rst = 1'b1;
    tick; // cycle 47
    i_rst = 1'b0;
    n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_req: got req=%b addr=%h want req=1 addr=00000000", o_imem_req, o_imem_addr); end
    n_cmp++; if (o_valid !== 1'b0 || o_instruction !== 32'h0000_0013) begin n_fail++; $display("FAIL rm_bubble: got v=%b i=%h want v=0 i=00000013", o_valid, o_instruction); end
    for (int k = 0; k < 4; k++) begin // cycles 48..51
      tick;
      n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rm_latency%0d: got v=%b want 0", k, o_valid); end
    end
    tick; // cycle 52
    n_cmp++; if (o_valid !== 1'b1 || o_pc !== 32'h0 || o_instruction !== 32'h0010_0093) begin n_fail++; $display("FAIL rm_out0: got v=%b pc=%h i=%h want v=1 pc=00000000 i=00100093", o_valid, o_pc, o_instruction); end
  endtask

  task automatic test_wrap;
    mem_lat = 1;
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFF;
    tick; // cycle 53
    i_redirect = 1'b0;
    n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_align: got req=%b addr=%h want req=1 addr=fffffffc", o_imem_req, o_imem_addr); end
    tick; tick; // cycle 55
    n_cmp++; if (o_valid !== 1'b1 || o_pc !== 32'hFFFF_FFFC || o_instruction !== 32'hC0DE_FFFC) begin n_fail++; $display("FAIL wr_out: got v=%b pc=%h i=%h want v=1 pc=fffffffc i=c0defffc", o_valid, o_pc, o_instruction); end
    tick; // cycle 56
    n_cmp++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL wr_wrap: got req=%b addr=%h want req=1 addr=00000000", o_imem_req, o_imem_addr); end
  endtask

  initial begin
    test_reset;
    test_stall;
    test_redirect_priority;
    test_redirect_wait;
    test_multi_redirect;
    test_redirect_with_valid;
    test_reset_mid;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front end of the pipeline: owns the program counter, fetches one 32-bit instruction at a time from instruction memory over a single-outstanding request/response interface, and presents `o_pc`/`o_instruction` to the instruction decode stage. Accepts stalls from hazard logic and redirects (taken branch / jump) from the execute stage. Discards in-flight responses made stale by a redirect. Emits a NOP bubble whenever no valid instruction is held.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset.
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`) driven when `o_valid`=0.

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `o_imem_req`  out  1  one-cycle request pulse.
- `o_imem_addr`  out  32  fetch address; valid when `o_imem_req`=1.
- `i_imem_valid`  in  1  response strobe, one cycle, ≥1 cycle after request.
- `i_imem_rdata`  in  32  instruction word; valid with `i_imem_valid`.
- `i_stall`  in  1  hold the current output instruction.
- `i_redirect`  in  1  change fetch stream.
- `i_redirect_pc`  in  32  redirect target; bits [1:0] ignored.
- `o_valid`  out  1  `o_pc`/`o_instruction` carry a real instruction.
- `o_pc`  out  32  PC of presented instruction.
- `o_instruction`  out  32  instruction word, or `NOP_INSTR` when `o_valid`=0.

## Operation
- Registers: `pc`, `state`, `discard`, `instr_q`, `o_pc`, `o_valid`.
- `o_imem_req` = (state==S_REQ); `o_imem_addr` = `pc` (combinational from register).
- `o_instruction` = `o_valid` ? `instr_q` : `NOP_INSTR` (combinational mux).
- Redirect target always aligned: `pc` <= {`i_redirect_pc`[31:2], 2'b00}.
- S_REQ: request issued this cycle. Next S_WAIT. If `i_redirect`: request still goes out for old `pc`; `discard`<=1; `pc`<=target.
- S_WAIT: if `i_imem_valid` and (`discard` or `i_redirect`): drop data, `discard`<=0, `pc`<=target if redirecting, go S_REQ. If `i_imem_valid` otherwise: `instr_q`<=`i_imem_rdata`, `o_pc`<=`pc`, `o_valid`<=1, go S_OUT. If no response and `i_redirect`: `discard`<=1, `pc`<=target, stay.
- S_OUT: `i_redirect` (priority over stall): `o_valid`<=0, `pc`<=target, go S_REQ. Else `i_stall`: hold all, stay. Else: `o_valid`<=0, `pc`<=`pc`+4 (mod 2^32), go S_REQ.
- Multiple redirects before a response: last target wins; exactly one stale response dropped.
- `i_imem_valid` outside S_WAIT ignored. `i_stall` outside S_OUT ignored.
- `pc`+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.

## Timing
- Reset values: `state`=S_REQ, `pc`=`RESET_PC`, `o_pc`=`RESET_PC`, `o_valid`=0, `discard`=0, `instr_q`=`NOP_INSTR`. Thus `o_imem_req`=1, `o_imem_addr`=`RESET_PC` in first cycle after reset released; `o_instruction`=`NOP_INSTR`.
- Reset mid-operation returns to reset values next edge. Instruction memory shares `i_rst` and drops outstanding requests.
- Memory latency L≥1 cycles: request at cycle t, response at t+L, `o_valid`=1 at t+L+1, next request at t+L+2 (no stall). Throughput 1 instr per L+2 cycles.
- `o_valid` high exactly one cycle per instruction unless stalled; stays high, with stable `o_pc`/`o_instruction`, for every `i_stall` cycle.
- Redirect in S_OUT: `o_valid` low next cycle, request to target same next cycle.
- At most one outstanding request at any time.

## Test plan
- Reset, L=1, mem[0]=32'h0010_0093: req at 0x0 cycle 0, `o_valid`=1 cycle 2 with `o_pc`=0x0, `o_instruction`=32'h0010_0093; next req addr 0x4 cycle 3.
- Stall 3 cycles while S_OUT at 0x8: `o_valid`, `o_pc`=0x8, instruction stable 4 cycles; after release request addr 0xC; no extra request during stall.
- Redirect to 0x103 in S_OUT, same cycle `i_stall`=1: stall ignored, `o_valid`=0 next cycle, request addr 0x100.
- L=4, redirect to 0x200 two cycles after request to 0x10: 0x10 response dropped (`o_valid` stays 0), next request 0x200, its data presented with `o_pc`=0x200.
- Redirect to 0x300 coinciding with `i_imem_valid` in S_WAIT: data dropped, request 0x300 next cycle, `discard`=0 afterward.
- `i_rst` asserted during S_WAIT at pc 0x40: next cycle req at `RESET_PC`, `o_valid`=0, `o_instruction`=32'h0000_0013.
